// File: rtl/screen_sequencer_pkg.sv
// Shared sizes and helpers for the screen sequencer: framebuffer geometry and screen rotation.
// Pure declarations; no latency, no flow control.
package screen_sequencer_pkg;

  localparam int DISP_ADDR_WIDTH   = 17;
  localparam int FB_PIXELS_DEFAULT = 76800;
  localparam int FB_DATA_WIDTH     = 32;
  localparam int COLOUR_WIDTH      = 12;

  function automatic logic [1:0] next_screen(input logic [1:0] cur, input int num);
    return (cur == 2'(num - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/screen_sequencer_clear_walker.sv
// Clear address generator: walks 0..FB_PIXELS-1, one address per cycle, busy from reset or start.
// Address is combinational from the counter; there is no backpressure.
module fb_clear_walker
  import screen_sequencer_pkg::*;
#(
  parameter int FB_PIXELS = FB_PIXELS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic [DISP_ADDR_WIDTH-1:0] addr_o,
  output logic                       last_o
);

  logic [DISP_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                       busy_q, busy_d;

  assign last_o = busy_q && (cnt_q == DISP_ADDR_WIDTH'(FB_PIXELS - 1));
  assign busy_o = busy_q;
  assign addr_o = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      if (last_o) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (start_i) begin
      busy_d = 1'b1;
    end
  end

  // A walk is already in progress coming out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Multiplexes N screens onto one framebuffer write port, clearing the buffer between screens.
// All outputs registered (one-cycle latency from the active screen); no backpressure.
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int         NUM_SCREENS  = 4,
  parameter int         FB_PIXELS    = FB_PIXELS_DEFAULT,
  parameter logic [11:0] CLEAR_COLOUR = 12'h000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_SCREENS-1:0]                 scr_fb_we,
  input  logic [NUM_SCREENS*DISP_ADDR_WIDTH-1:0] scr_fb_addr,
  input  logic [NUM_SCREENS*FB_DATA_WIDTH-1:0]   scr_fb_wdata,
  input  logic [NUM_SCREENS-1:0]                 scr_done,
  output logic [NUM_SCREENS-1:0]                 scr_reset,
  output logic                                   fb_we,
  output logic [DISP_ADDR_WIDTH-1:0]             fb_addr,
  output logic [FB_DATA_WIDTH-1:0]               fb_wdata,
  output logic [1:0]                             active_screen,
  output logic                                   clearing
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  localparam logic [NUM_SCREENS-1:0] SCR_ONE = {{(NUM_SCREENS-1){1'b0}}, 1'b1};

  typedef enum logic {S_CLEAR = ST_CLEAR, S_RUN = ST_RUN} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 active_q, active_d;
  logic [NUM_SCREENS-1:0]     scr_reset_q, scr_reset_d;
  logic                       fb_we_q, fb_we_d;
  logic [DISP_ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic [FB_DATA_WIDTH-1:0]   fb_wdata_q, fb_wdata_d;

  logic                       clr_busy, clr_last, done_act;
  logic [DISP_ADDR_WIDTH-1:0] clr_addr;

  assign done_act = scr_done[active_q];

  fb_clear_walker #(
    .FB_PIXELS (FB_PIXELS)
  ) u_walker (
    .clk     (clk),
    .reset   (reset),
    .start_i ((state_q == S_RUN) && done_act),
    .busy_o  (clr_busy),
    .addr_o  (clr_addr),
    .last_o  (clr_last)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    scr_reset_d = scr_reset_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = '0;
    fb_wdata_d  = '0;
    case (state_q)
      S_CLEAR: begin
        fb_we_d    = clr_busy;
        fb_addr_d  = clr_addr;
        fb_wdata_d = {20'd0, CLEAR_COLOUR};
        if (clr_last) begin
          state_d     = S_RUN;
          scr_reset_d = ~(SCR_ONE << active_q);
        end
      end
      S_RUN: begin
        // The active screen's write still goes out in the cycle it signals done.
        fb_we_d    = scr_fb_we[active_q];
        fb_addr_d  = scr_fb_addr[active_q*DISP_ADDR_WIDTH +: DISP_ADDR_WIDTH];
        fb_wdata_d = scr_fb_wdata[active_q*FB_DATA_WIDTH +: FB_DATA_WIDTH];
        if (done_act) begin
          state_d     = S_CLEAR;
          active_d    = next_screen(active_q, NUM_SCREENS);
          scr_reset_d = '1;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      active_q    <= 2'd0;
      scr_reset_q <= '1;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      scr_reset_q <= scr_reset_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
    end
  end

  assign scr_reset     = scr_reset_q;
  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_wdata      = fb_wdata_q;
  assign active_screen = active_q;
  assign clearing      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a shortened framebuffer and a non-zero clear colour.
module tb_screen_sequencer;
  import screen_sequencer_pkg::*;

  localparam int          NS = 4;
  localparam int          FB = 64;
  localparam int          AW = DISP_ADDR_WIDTH;
  localparam logic [11:0] CC = 12'h5A3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     scr_fb_we;
  logic [NS*AW-1:0]  scr_fb_addr;
  logic [NS*32-1:0]  scr_fb_wdata;
  logic [NS-1:0]     scr_done;
  logic [NS-1:0]     scr_reset;
  logic              fb_we;
  logic [AW-1:0]     fb_addr;
  logic [31:0]       fb_wdata;
  logic [1:0]        active_screen;
  logic              clearing;

  int n_chk  = 0;
  int n_fail = 0;

  screen_sequencer #(
    .NUM_SCREENS  (NS),
    .FB_PIXELS    (FB),
    .CLEAR_COLOUR (CC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .scr_fb_we     (scr_fb_we),
    .scr_fb_addr   (scr_fb_addr),
    .scr_fb_wdata  (scr_fb_wdata),
    .scr_done      (scr_done),
    .scr_reset     (scr_reset),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_wdata      (fb_wdata),
    .active_screen (active_screen),
    .clearing      (clearing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] run_rst(input logic [1:0] a);
    return 4'b1111 & ~(4'b0001 << a);
  endfunction

  task automatic drive_scr(input int s, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    scr_fb_we[s]              = we;
    scr_fb_addr[s*AW +: AW]   = a;
    scr_fb_wdata[s*32 +: 32]  = d;
  endtask

  // Entered when the next rising edge registers clear write 0; also pulses every done line mid-clear.
  task automatic verify_clear(input string tag, input logic [1:0] act);
    int good;
    good = 0;
    for (int i = 0; i < FB; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (fb_we === 1'b1 && fb_addr === AW'(i) && fb_wdata === 32'(CC) &&
          clearing === (i != FB - 1) && active_screen === act &&
          (i == FB - 1 || scr_reset === 4'b1111))
        good++;
      if (i == 2) scr_done = '1;
      else if (i == 3) scr_done = '0;
    end
    chk({tag, "_writes"}, good, FB);
    chk({tag, "_clearing"}, clearing, 1'b0);
    chk({tag, "_scr_reset"}, scr_reset, run_rst(act));
    chk({tag, "_active"}, active_screen, act);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [1:0] cur, nxt;
    reset        = 1'b1;
    scr_fb_we    = '0;
    scr_fb_addr  = '0;
    scr_fb_wdata = '0;
    scr_done     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_fb_addr", fb_addr, '0);
    chk("rst_fb_wdata", fb_wdata, '0);
    chk("rst_scr_reset", scr_reset, 4'b1111);
    chk("rst_clearing", clearing, 1'b1);
    chk("rst_active", active_screen, 2'd0);

    reset = 1'b0;
    verify_clear("clr0", 2'd0);

    // Screen 0 forwarded with one cycle of latency; screen 1 never.
    drive_scr(0, 1'b1, 17'd5, 32'hABC);
    drive_scr(1, 1'b1, 17'd9, 32'hDEF);
    @(posedge clk);
    @(negedge clk);
    chk("run_we", fb_we, 1'b1);
    chk("run_addr", fb_addr, 17'd5);
    chk("run_wdata", fb_wdata, 32'hABC);
    drive_scr(0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("inactive_we", fb_we, 1'b0);
    drive_scr(1, 1'b0, '0, '0);

    scr_done = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    scr_done = '0;
    chk("xdone_clearing", clearing, 1'b0);
    chk("xdone_active", active_screen, 2'd0);
    chk("xdone_scr_reset", scr_reset, 4'b1110);

    drive_scr(0, 1'b1, 17'd7, 32'h123);
    scr_done = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    scr_done = '0;
    drive_scr(0, 1'b0, '0, '0);
    chk("done_fwd_we", fb_we, 1'b1);
    chk("done_fwd_addr", fb_addr, 17'd7);
    chk("done_fwd_wdata", fb_wdata, 32'h123);
    chk("done_clearing", clearing, 1'b1);
    chk("done_active", active_screen, 2'd1);
    chk("done_scr_reset", scr_reset, 4'b1111);
    verify_clear("clr1", 2'd1);

    for (int k = 0; k < 3; k++) begin
      cur = 2'(k + 1);
      nxt = 2'((k + 2) % 4);
      scr_done = 4'b0001 << cur;
      @(posedge clk);
      @(negedge clk);
      scr_done = '0;
      chk("rot_active", active_screen, nxt);
      chk("rot_clearing", clearing, 1'b1);
      verify_clear("rot", nxt);
    end

    // Reset lands while the clear counter holds 40.
    scr_done = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    scr_done = '0;
    chk("mid_active", active_screen, 2'd1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("mid_addr", fb_addr, 17'd39);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rr_active", active_screen, 2'd0);
    chk("rr_fb_we", fb_we, 1'b0);
    chk("rr_clearing", clearing, 1'b1);
    chk("rr_scr_reset", scr_reset, 4'b1111);
    reset = 1'b0;
    verify_clear("clr_rst", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
